// File: rtl/crc_stream.sv
// Framed streaming CRC engine. Consumes a byte-keep valid/ready stream,
// runs a runtime-configurable Galois LFSR over every accepted byte and
// presents one result (CRC, byte count, compare flag) per frame. A pending
// result blocks the input so that frames never overlap.
module crc_stream #(
    parameter int DATA_WIDTH = 32,
    parameter int CRC_WIDTH  = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [CRC_WIDTH:0]        cfg_poly,
    input  logic [CRC_WIDTH-1:0]      cfg_init,
    input  logic [CRC_WIDTH-1:0]      cfg_xorout,
    input  logic                      cfg_refin,
    input  logic                      cfg_refout,
    input  logic [CRC_WIDTH-1:0]      cfg_expected,
    input  logic [DATA_WIDTH-1:0]     s_tdata,
    input  logic [DATA_WIDTH/8-1:0]   s_tkeep,
    input  logic                      s_tlast,
    input  logic                      s_tvalid,
    output logic                      s_tready,
    output logic [CRC_WIDTH-1:0]      m_crc,
    output logic [LEN_WIDTH-1:0]      m_len,
    output logic                      m_match,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic                      busy
);

    localparam int KEEP_WIDTH = DATA_WIDTH / 8;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Frame state and shadow configuration
    logic [0:0]           state_q,    state_d;
    logic [CRC_WIDTH:0]   poly_q,     poly_d;
    logic [CRC_WIDTH-1:0] xorout_q,   xorout_d;
    logic                 refin_q,    refin_d;
    logic                 refout_q,   refout_d;
    logic [CRC_WIDTH-1:0] expected_q, expected_d;
    logic [CRC_WIDTH-1:0] lfsr_q,     lfsr_d;
    logic [LEN_WIDTH-1:0] len_q,      len_d;

    // Result registers
    logic [CRC_WIDTH-1:0] m_crc_q,    m_crc_d;
    logic [LEN_WIDTH-1:0] m_len_q,    m_len_d;
    logic                 m_match_q,  m_match_d;
    logic                 m_valid_q,  m_valid_d;

    // Beat datapath
    logic                 accept;
    logic                 start;
    logic [CRC_WIDTH:0]   poly_e;
    logic [CRC_WIDTH-1:0] xorout_e;
    logic                 refin_e;
    logic                 refout_e;
    logic [CRC_WIDTH-1:0] expected_e;
    int                   deg;
    int                   nbytes;
    logic [CRC_WIDTH-1:0] mask;
    logic [CRC_WIDTH-1:0] crc_w;
    logic [CRC_WIDTH-1:0] sel;
    logic [CRC_WIDTH-1:0] rev;
    logic [CRC_WIDTH-1:0] result;
    logic                 live;
    logic                 bit_in;
    logic                 fb;
    logic [LEN_WIDTH:0]   len_sum;
    logic [LEN_WIDTH-1:0] len_new;

    assign s_tready = ~m_valid_q;
    assign m_crc    = m_crc_q;
    assign m_len    = m_len_q;
    assign m_match  = m_match_q;
    assign m_valid  = m_valid_q;
    assign busy     = (state_q == ST_RUN);

    // Whole-beat CRC update: all kept bytes stepped bit-serially in one cycle
    always_comb begin
        accept     = s_tvalid & ~m_valid_q;
        start      = (state_q == ST_IDLE);
        // The first beat of a frame works from the live config; later beats from the shadow copy
        poly_e     = start ? cfg_poly     : poly_q;
        xorout_e   = start ? cfg_xorout   : xorout_q;
        refin_e    = start ? cfg_refin    : refin_q;
        refout_e   = start ? cfg_refout   : refout_q;
        expected_e = start ? cfg_expected : expected_q;

        deg = 0;
        for (int i = 0; i <= CRC_WIDTH; i++) begin
            if (poly_e[i]) deg = i;
        end
        mask = '0;
        for (int i = 0; i < CRC_WIDTH; i++) begin
            mask[i] = (i < deg);
        end

        crc_w  = (start ? cfg_init : lfsr_q) & mask;
        nbytes = 0;
        live   = 1'b1;
        bit_in = 1'b0;
        fb     = 1'b0;
        sel    = '0;
        for (int b = 0; b < KEEP_WIDTH; b++) begin
            // Only the low-contiguous run of keep bits counts
            live = live & s_tkeep[b];
            if (live) begin
                nbytes = nbytes + 1;
                for (int j = 0; j < 8; j++) begin
                    bit_in = refin_e ? s_tdata[8*b + j] : s_tdata[8*b + 7 - j];
                    fb     = bit_in;
                    if (deg != 0) begin
                        sel = {{(CRC_WIDTH-1){1'b0}}, 1'b1} << (deg - 1);
                        fb  = bit_in ^ (|(crc_w & sel));
                    end
                    crc_w = ((crc_w << 1) ^ (fb ? poly_e[CRC_WIDTH-1:0] : '0)) & mask;
                end
            end
        end

        // Reflection spans only the active degree, not the full register
        rev = '0;
        for (int i = 0; i < CRC_WIDTH; i++) begin
            if (i < deg) begin
                sel    = {{(CRC_WIDTH-1){1'b0}}, 1'b1} << (deg - 1 - i);
                rev[i] = |(crc_w & sel);
            end
        end
        result = (refout_e ? rev : crc_w) ^ (xorout_e & mask);

        len_sum = {1'b0, (start ? {LEN_WIDTH{1'b0}} : len_q)} + (LEN_WIDTH+1)'(nbytes);
        len_new = len_sum[LEN_WIDTH] ? {LEN_WIDTH{1'b1}} : len_sum[LEN_WIDTH-1:0];
    end

    // Frame FSM, shadow config capture and result generation
    always_comb begin
        state_d    = state_q;
        poly_d     = poly_q;
        xorout_d   = xorout_q;
        refin_d    = refin_q;
        refout_d   = refout_q;
        expected_d = expected_q;
        lfsr_d     = lfsr_q;
        len_d      = len_q;
        m_crc_d    = m_crc_q;
        m_len_d    = m_len_q;
        m_match_d  = m_match_q;
        m_valid_d  = m_valid_q;

        if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end

        if (accept) begin
            if (start) begin
                poly_d     = cfg_poly;
                xorout_d   = cfg_xorout;
                refin_d    = cfg_refin;
                refout_d   = cfg_refout;
                expected_d = cfg_expected;
            end
            lfsr_d = crc_w;
            len_d  = len_new;
            if (s_tlast) begin
                m_valid_d = 1'b1;
                m_crc_d   = result;
                m_len_d   = len_new;
                m_match_d = (result == expected_e);
                state_d   = ST_IDLE;
            end else begin
                state_d   = ST_RUN;
            end
        end
    end

    // State registers; reset discards any frame in flight immediately
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            poly_q     <= '0;
            xorout_q   <= '0;
            refin_q    <= 1'b0;
            refout_q   <= 1'b0;
            expected_q <= '0;
            lfsr_q     <= '0;
            len_q      <= '0;
            m_crc_q    <= '0;
            m_len_q    <= '0;
            m_match_q  <= 1'b0;
            m_valid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            poly_q     <= poly_d;
            xorout_q   <= xorout_d;
            refin_q    <= refin_d;
            refout_q   <= refout_d;
            expected_q <= expected_d;
            lfsr_q     <= lfsr_d;
            len_q      <= len_d;
            m_crc_q    <= m_crc_d;
            m_len_q    <= m_len_d;
            m_match_q  <= m_match_d;
            m_valid_q  <= m_valid_d;
        end
    end

endmodule

// File: tb/tb_crc_stream.sv
// Bench for crc_stream: directed frames with known CRC answers, plus a
// byte-queue reference model compared against the outputs every cycle.
module tb_crc_stream;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [32:0] cfg_poly = '0;
    logic [31:0] cfg_init = '0;
    logic [31:0] cfg_xorout = '0;
    logic        cfg_refin = 1'b0;
    logic        cfg_refout = 1'b0;
    logic [31:0] cfg_expected = '0;
    logic [31:0] s_tdata = '0;
    logic [3:0]  s_tkeep = '0;
    logic        s_tlast = 1'b0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [31:0] m_crc;
    logic [15:0] m_len;
    logic        m_match;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic        busy;

    int checks = 0;
    int errors = 0;

    crc_stream dut (
        .clk(clk), .resetn(resetn),
        .cfg_poly(cfg_poly), .cfg_init(cfg_init), .cfg_xorout(cfg_xorout),
        .cfg_refin(cfg_refin), .cfg_refout(cfg_refout), .cfg_expected(cfg_expected),
        .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast),
        .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_crc(m_crc), .m_len(m_len), .m_match(m_match),
        .m_valid(m_valid), .m_ready(m_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    byte unsigned mdl_q[$];
    logic [32:0]  sh_poly = '0;
    logic [31:0]  sh_init = '0, sh_xor = '0, sh_exp = '0;
    logic         sh_refin = 1'b0, sh_refout = 1'b0;
    logic         mdl_valid = 1'b0, mdl_busy = 1'b0, mdl_match = 1'b0;
    logic [31:0]  mdl_crc = '0;
    int           mdl_len = 0;

    function automatic logic [31:0] ref_crc();
        int deg = 0;
        longint unsigned mask, s, r, p;
        byte unsigned bv;
        logic b, fb;
        for (int i = 0; i <= 32; i++) if (sh_poly[i]) deg = i;
        if (deg == 0) return 32'h0;
        mask = (64'd1 << deg) - 1;
        p = 64'(sh_poly);
        s = 64'(sh_init) & mask;
        foreach (mdl_q[n]) begin
            bv = mdl_q[n];
            for (int k = 0; k < 8; k++) begin
                b  = sh_refin ? bv[k] : bv[7-k];
                fb = 1'(s >> (deg - 1)) ^ b;
                s  = ((s << 1) ^ (fb ? p : 64'd0)) & mask;
            end
        end
        r = s;
        if (sh_refout) begin
            r = 0;
            for (int i = 0; i < deg; i++)
                if (((s >> i) & 64'd1) != 0) r = r | (64'd1 << (deg - 1 - i));
        end
        r = r ^ (64'(sh_xor) & mask);
        return r[31:0];
    endfunction

    initial begin
        logic acc;
        forever begin
            @(posedge clk or negedge resetn);
            if (!resetn) begin
                mdl_valid = 0; mdl_busy = 0; mdl_crc = 0; mdl_len = 0; mdl_match = 0;
                mdl_q.delete();
            end else begin
                acc = s_tvalid && !mdl_valid;
                if (mdl_valid && m_ready) mdl_valid = 0;
                if (acc) begin
                    if (!mdl_busy) begin
                        sh_poly = cfg_poly; sh_init = cfg_init; sh_xor = cfg_xorout;
                        sh_refin = cfg_refin; sh_refout = cfg_refout; sh_exp = cfg_expected;
                        mdl_q.delete();
                    end
                    for (int b = 0; b < 4; b++) begin
                        if (!s_tkeep[b]) break;
                        mdl_q.push_back(s_tdata[8*b +: 8]);
                    end
                    if (s_tlast) begin
                        mdl_crc   = ref_crc();
                        mdl_len   = (mdl_q.size() > 65535) ? 65535 : mdl_q.size();
                        mdl_match = (mdl_crc == sh_exp);
                        mdl_valid = 1;
                        mdl_busy  = 0;
                    end else begin
                        mdl_busy = 1;
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            if (resetn) begin
                chk("tready", 64'(s_tready), 64'(!mdl_valid));
                chk("m_valid", 64'(m_valid), 64'(mdl_valid));
                chk("busy", 64'(busy), 64'(mdl_busy));
                if (mdl_valid) begin
                    chk("m_crc", 64'(m_crc), 64'(mdl_crc));
                    chk("m_len", 64'(m_len), 64'(mdl_len));
                    chk("m_match", 64'(m_match), 64'(mdl_match));
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_cfg(input logic [32:0] p, input logic [31:0] i, input logic [31:0] x,
                           input logic ri, input logic ro, input logic [31:0] e);
        cfg_poly = p; cfg_init = i; cfg_xorout = x;
        cfg_refin = ri; cfg_refout = ro; cfg_expected = e;
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        logic rdy;
        int n;
        s_tdata = d; s_tkeep = k; s_tlast = l; s_tvalid = 1'b1;
        n = 0;
        rdy = 1'b0;
        while (!rdy && n < 50) begin
            @(negedge clk);
            rdy = s_tready;
            @(posedge clk);
            n++;
        end
        if (!rdy) chk("beat_timeout", 64'(n), 64'd0);
        #1;
        s_tvalid = 1'b0;
    endtask

    task automatic send_123456789();
        send_beat(32'h34333231, 4'hF, 1'b0);
        send_beat(32'h38373635, 4'hF, 1'b0);
        send_beat(32'h00000039, 4'h1, 1'b1);
    endtask

    // Waits for the result, checks literal expectations, returns at posedge+1
    task automatic wait_result(input string name, input logic [31:0] crc, input logic [15:0] len,
                               input logic match, input bit chk_crc);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!m_valid && n < 100);
        chk({name, "_valid"}, 64'(m_valid), 64'd1);
        if (chk_crc) chk({name, "_crc"}, 64'(m_crc), 64'(crc));
        chk({name, "_len"}, 64'(m_len), 64'(len));
        chk({name, "_match"}, 64'(m_match), 64'(match));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at t=%0t", $time);
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        logic rdy;
        int n;

        // Reset values
        #3;
        chk("rst_valid", 64'(m_valid), 64'd0);
        chk("rst_crc", 64'(m_crc), 64'd0);
        chk("rst_len", 64'(m_len), 64'd0);
        chk("rst_match", 64'(m_match), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_tready", 64'(s_tready), 64'd1);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;

        // Standard algorithms on "123456789"
        set_cfg(33'h104C11DB7, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1, 32'hCBF43926);
        send_123456789();
        wait_result("crc32", 32'hCBF43926, 16'd9, 1'b1, 1);

        set_cfg(33'h11021, 32'h0000FFFF, 32'h0, 0, 0, 32'h0);
        send_123456789();
        wait_result("ccitt", 32'h000029B1, 16'd9, 1'b0, 1);

        set_cfg(33'h18005, 32'h0, 32'h0, 1, 1, 32'h0);
        send_123456789();
        wait_result("arc", 32'h0000BB3D, 16'd9, 1'b0, 1);

        set_cfg(33'h107, 32'h0, 32'h0, 0, 0, 32'h000000F4);
        send_123456789();
        wait_result("crc8", 32'h000000F4, 16'd9, 1'b1, 1);

        // Backpressure: result held, early beat of next frame waits
        set_cfg(33'h104C11DB7, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1, 32'hCBF43926);
        m_ready = 1'b0;
        send_123456789();
        wait_result("bp1", 32'hCBF43926, 16'd9, 1'b1, 1);
        s_tdata = 32'h34333231; s_tkeep = 4'hF; s_tlast = 1'b0; s_tvalid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_tready", 64'(s_tready), 64'd0);
            chk("bp_hold_crc", 64'(m_crc), 64'hCBF43926);
        end
        @(posedge clk); #1;
        m_ready = 1'b1;
        n = 0;
        rdy = 1'b0;
        while (!rdy && n < 20) begin
            @(negedge clk);
            rdy = s_tready;
            @(posedge clk);
            n++;
        end
        chk("bp_accept_cycles", 64'(n), 64'd2);
        #1;
        s_tvalid = 1'b0;
        send_beat(32'h38373635, 4'hF, 1'b0);
        send_beat(32'h00000039, 4'h1, 1'b1);
        wait_result("bp2", 32'hCBF43926, 16'd9, 1'b1, 1);

        // Config change mid-frame is ignored, including the compare value
        set_cfg(33'h104C11DB7, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1, 32'hCBF43926);
        send_beat(32'h34333231, 4'hF, 1'b0);
        set_cfg(33'h11021, 32'h0000FFFF, 32'h0, 0, 0, 32'h0);
        send_beat(32'h38373635, 4'hF, 1'b0);
        send_beat(32'h00000039, 4'h1, 1'b1);
        wait_result("midcfg", 32'hCBF43926, 16'd9, 1'b1, 1);

        // Mismatching compare value
        set_cfg(33'h104C11DB7, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1, 32'h0);
        send_123456789();
        wait_result("nomatch", 32'hCBF43926, 16'd9, 1'b0, 1);

        // Empty beat mid-frame and non-contiguous keep on the last beat
        send_beat(32'h34333231, 4'hF, 1'b0);
        send_beat(32'hDEADBEEF, 4'h0, 1'b0);
        send_beat(32'h38373635, 4'hF, 1'b0);
        send_beat(32'hAA00BB39, 4'b0101, 1'b1);
        wait_result("keep", 32'hCBF43926, 16'd9, 1'b0, 1);

        // Zero-length frame
        send_beat(32'h12345678, 4'h0, 1'b1);
        wait_result("zero", 32'h0, 16'd0, 1'b1, 1);

        // Degree 0 polynomial forces CRC to zero
        set_cfg(33'h1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1, 32'h0);
        send_123456789();
        wait_result("deg0", 32'h0, 16'd9, 1'b1, 1);

        // Asynchronous reset mid-frame
        set_cfg(33'h104C11DB7, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1, 32'hCBF43926);
        send_beat(32'h34333231, 4'hF, 1'b0);
        send_beat(32'h38373635, 4'hF, 1'b0);
        @(negedge clk); #2;
        resetn = 1'b0;
        #1;
        chk("arst_valid", 64'(m_valid), 64'd0);
        chk("arst_crc", 64'(m_crc), 64'd0);
        chk("arst_len", 64'(m_len), 64'd0);
        chk("arst_match", 64'(m_match), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        send_123456789();
        wait_result("post_rst", 32'hCBF43926, 16'd9, 1'b1, 1);

        // Length counter saturation (65600 bytes)
        set_cfg(33'h11021, 32'h0000FFFF, 32'h0, 0, 0, 32'h0);
        for (int i = 0; i < 16400; i++)
            send_beat(32'(i) ^ 32'hA5C3_0F1E, 4'hF, (i == 16399));
        wait_result("sat", 32'h0, 16'hFFFF, 1'b0, 0);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
